// File: rtl/dtw_traceback.sv
// DTW warping-path traceback: stores per-cell predecessor codes from the PE array,
// then walks from (last_t,last_r) back to (0,0) emitting one path point per handshake.
module dtw_traceback #(
    parameter int IDXW = 5,
    parameter int DW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_tidx,
    input  logic [IDXW-1:0] wr_ridx,
    input  logic [1:0]      wr_path,
    input  logic [DW-1:0]   wr_dist,
    input  logic            start,
    input  logic [IDXW-1:0] last_t,
    input  logic [IDXW-1:0] last_r,
    output logic            busy,
    output logic            step_valid,
    input  logic            step_ready,
    output logic [IDXW-1:0] step_tidx,
    output logic [IDXW-1:0] step_ridx,
    output logic            done,
    output logic            err,
    output logic [IDXW:0]   warp_len,
    output logic [DW-1:0]   final_dist
);
    localparam int AW = 2 * IDXW;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WALK = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    // Longest monotone path in an NxN grid is 2N-1 points, i.e. all ones at IDXW+1 bits.
    localparam logic [IDXW:0] LEN_MAX = '1;

    logic [1:0] path_mem [0:(2**AW)-1];

    logic [1:0]      state_q, state_d;
    logic [IDXW-1:0] pt_t_q, pt_t_d, pt_r_q, pt_r_d;
    logic [IDXW:0]   len_q, len_d;
    logic            err_q, err_d;
    logic [DW-1:0]   fdist_q, fdist_d, dist_q, dist_d;
    logic [AW-1:0]   lastwr_q, lastwr_d;
    logic            wr_acc;
    logic [1:0]      code;

    assign wr_acc = wr_en && (state_q == S_IDLE);
    assign code   = path_mem[{pt_t_q, pt_r_q}];

    // No reset on the path memory: contents survive reset and start.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) path_mem[{wr_tidx, wr_ridx}] <= wr_path;
    end

    always_comb begin
        state_d  = state_q;
        pt_t_d   = pt_t_q;
        pt_r_d   = pt_r_q;
        len_d    = len_q;
        err_d    = err_q;
        fdist_d  = fdist_q;
        dist_d   = dist_q;
        lastwr_d = lastwr_q;
        if (wr_acc) begin
            dist_d   = wr_dist;
            lastwr_d = {wr_tidx, wr_ridx};
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WALK;
                    pt_t_d  = last_t;
                    pt_r_d  = last_r;
                    len_d   = '0;
                    err_d   = 1'b0;
                    fdist_d = (lastwr_q == {last_t, last_r}) ? dist_q : '0;
                end
            end
            S_WALK: begin
                if (step_ready) begin
                    if (len_q != LEN_MAX) len_d = len_q + (IDXW+1)'(1);
                    // Edges of the matrix force the move regardless of the stored code.
                    if (pt_t_q == '0 && pt_r_q == '0) begin
                        state_d = S_FIN;
                    end else if (pt_t_q == '0) begin
                        pt_r_d = pt_r_q - IDXW'(1);
                    end else if (pt_r_q == '0) begin
                        pt_t_d = pt_t_q - IDXW'(1);
                    end else begin
                        case (code)
                            2'b11: begin
                                pt_t_d = pt_t_q - IDXW'(1);
                                pt_r_d = pt_r_q - IDXW'(1);
                            end
                            2'b10: pt_t_d = pt_t_q - IDXW'(1);
                            2'b01: pt_r_d = pt_r_q - IDXW'(1);
                            default: begin
                                state_d = S_FIN;
                                err_d   = 1'b1;
                            end
                        endcase
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pt_t_q   <= '0;
            pt_r_q   <= '0;
            len_q    <= '0;
            err_q    <= 1'b0;
            fdist_q  <= '0;
            dist_q   <= '0;
            lastwr_q <= '0;
        end else begin
            state_q  <= state_d;
            pt_t_q   <= pt_t_d;
            pt_r_q   <= pt_r_d;
            len_q    <= len_d;
            err_q    <= err_d;
            fdist_q  <= fdist_d;
            dist_q   <= dist_d;
            lastwr_q <= lastwr_d;
        end
    end

    assign step_valid = (state_q == S_WALK);
    assign done       = (state_q == S_FIN);
    assign busy       = step_valid || done;
    assign step_tidx  = pt_t_q;
    assign step_ridx  = pt_r_q;
    assign err        = err_q;
    assign warp_len   = len_q;
    assign final_dist = fdist_q;
endmodule
